// File: rtl/clk_freq_monitor.sv
// Multi-channel clock frequency monitor: counts synchronised toggle edges per
// channel over a fixed sys_clk window and flags counts outside per-channel limits.

module clk_freq_monitor_lane #(
   parameter int CNT_W = 32
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             chan_tgl,
   input  logic             clr,
   output logic [CNT_W-1:0] sum
);
   logic             sync1, sync2, hist, edge_det;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= chan_tgl;
         sync2 <= sync1;
         hist  <= sync2;
         cnt   <= clr ? '0 : sum;
      end
   end

   // Both toggle polarities are edges; sum is the count including this cycle's edge.
   assign edge_det = sync2 ^ hist;
   assign sum      = (edge_det && (cnt != '1)) ? cnt + 1'b1 : cnt;
endmodule

module clk_freq_monitor #(
   parameter int                      N_CH        = 4,
   parameter int                      CNT_W       = 32,
   parameter int                      GATE_CYCLES = 100_000,
   parameter logic [N_CH*CNT_W-1:0]   EXP_MIN     = '0,
   parameter logic [N_CH*CNT_W-1:0]   EXP_MAX     = '1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  mon_en,
   input  logic [N_CH-1:0]       chan_tgl,
   output logic [N_CH*CNT_W-1:0] meas_cnt,
   output logic                  meas_valid,
   output logic [N_CH-1:0]       ch_ok,
   output logic [N_CH-1:0]       ch_dead,
   output logic                  busy
);
   localparam int               WIN_W    = $clog2(GATE_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

   state_t                        state;
   logic [WIN_W-1:0]              win;
   logic                          term, clr;
   logic [N_CH-1:0][CNT_W-1:0]    sum, lim_lo, lim_hi;
   logic [N_CH-1:0]               ok_nxt, dead_nxt;

   assign lim_lo = EXP_MIN;
   assign lim_hi = EXP_MAX;
   assign term   = (win == WIN_LAST);
   // Counters restart on every window boundary so the terminal edge lands in the closing window.
   assign clr    = (state == IDLE) || term;
   assign busy   = (state != IDLE);

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_lane
         clk_freq_monitor_lane #(.CNT_W(CNT_W)) u_lane (
            .sys_clk  (sys_clk),
            .sys_rst  (sys_rst),
            .chan_tgl (chan_tgl[i]),
            .clr      (clr),
            .sum      (sum[i])
         );
         assign ok_nxt[i]   = (sum[i] >= lim_lo[i]) && (sum[i] <= lim_hi[i]);
         assign dead_nxt[i] = (sum[i] == '0);
      end
   endgenerate

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         win        <= '0;
         meas_cnt   <= '0;
         ch_ok      <= '0;
         ch_dead    <= '0;
         meas_valid <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         win        <= clr ? '0 : win + 1'b1;
         case (state)
            IDLE:
               if (mon_en) state <= SETTLE;
            SETTLE:
               if (!mon_en) begin
                  state <= IDLE;
                  win   <= '0;
               end else if (term) begin
                  state <= RUN;
               end
            RUN: begin
               // A terminal-cycle latch completes even if mon_en drops on it.
               if (term) begin
                  meas_cnt   <= sum;
                  ch_ok      <= ok_nxt;
                  ch_dead    <= dead_nxt;
                  meas_valid <= 1'b1;
               end
               if (!mon_en) begin
                  state <= IDLE;
                  win   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor with a window/edge-count reference model.

module tb_clk_freq_monitor;
   localparam int N_CH = 4;
   localparam int CNT_W = 8;
   localparam int G = 1000;
   localparam int MAXV = (1 << CNT_W) - 1;
   localparam logic [N_CH*CNT_W-1:0] EMIN = {8'd0, 8'd1, 8'd0, 8'd190};
   localparam logic [N_CH*CNT_W-1:0] EMAX = {8'd255, 8'd255, 8'd255, 8'd210};

   logic                  sys_clk = 1'b0;
   logic                  sys_rst, mon_en;
   logic [N_CH-1:0]       chan_tgl, ch_ok, ch_dead;
   logic [N_CH*CNT_W-1:0] meas_cnt;
   logic                  meas_valid, busy;

   clk_freq_monitor #(
      .N_CH(N_CH), .CNT_W(CNT_W), .GATE_CYCLES(G), .EXP_MIN(EMIN), .EXP_MAX(EMAX)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .mon_en     (mon_en),
      .chan_tgl   (chan_tgl),
      .meas_cnt   (meas_cnt),
      .meas_valid (meas_valid),
      .ch_ok      (ch_ok),
      .ch_dead    (ch_dead),
      .busy       (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int per[N_CH];
   logic [N_CH-1:0] inj;
   logic [N_CH-1:0] ev[int];   // edge flags keyed by the clock edge that must count them

   // reference model state
   bit              m_active, m_valid;
   int              m_age;
   int              acc[N_CH], m_meas[N_CH];
   logic [N_CH-1:0] m_ok, m_dead;
   int              lo[N_CH] = '{190, 0, 1, 0};
   int              hi[N_CH] = '{210, 255, 255, 255};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int cnt_of(input int ch);
      return int'(meas_cnt[ch*CNT_W +: CNT_W]);
   endfunction

   task automatic model_reset();
      m_active = 0; m_valid = 0; m_age = 0; m_ok = '0; m_dead = '0;
      for (int c = 0; c < N_CH; c++) begin acc[c] = 0; m_meas[c] = 0; end
      ev.delete();
   endtask

   // Window index = age / G; index 0 is the settle window, later ones report.
   task automatic model_edge(input logic [N_CH-1:0] e);
      int  pos, total;
      bit  fin;
      m_valid = 0;
      if (!m_active) begin
         if (mon_en) begin m_active = 1; m_age = 0; end
         for (int c = 0; c < N_CH; c++) acc[c] = 0;
      end else begin
         pos = m_age % G;
         fin = (pos == G - 1);
         for (int c = 0; c < N_CH; c++) begin
            total = acc[c] + int'(e[c]);
            if (fin && m_age >= G) begin
               m_meas[c] = (total > MAXV) ? MAXV : total;
               m_ok[c]   = (m_meas[c] >= lo[c]) && (m_meas[c] <= hi[c]);
               m_dead[c] = (m_meas[c] == 0);
               m_valid   = 1;
            end
            acc[c] = fin ? 0 : total;
         end
         if (!mon_en) begin
            m_active = 0;
            for (int c = 0; c < N_CH; c++) acc[c] = 0;
         end else begin
            m_age++;
         end
      end
   endtask

   // One clock: update model at the edge, drive toggles after it, compare at negedge.
   task automatic step();
      logic [N_CH-1:0] e, t;
      @(posedge sys_clk);
      cyc++;
      e = ev.exists(cyc) ? ev[cyc] : '0;
      if (ev.exists(cyc)) ev.delete(cyc);
      if (!sys_rst) model_edge(e);
      #1;
      if (!sys_rst) begin
         t = inj;
         for (int c = 0; c < N_CH; c++)
            if (per[c] != 0 && (cyc % per[c]) == 0) t[c] = 1'b1;
         chan_tgl = chan_tgl ^ t;
         if (t != '0) ev[cyc + 3] = t;
      end
      inj = '0;
      @(negedge sys_clk);
      chk("busy", busy, m_active);
      chk("meas_valid", meas_valid, m_valid);
      for (int c = 0; c < N_CH; c++) begin
         chk($sformatf("meas_cnt[%0d]", c), cnt_of(c), m_meas[c]);
         chk($sformatf("ch_ok[%0d]", c), ch_ok[c], m_ok[c]);
         chk($sformatf("ch_dead[%0d]", c), ch_dead[c], m_dead[c]);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!meas_valid && n < 2*G + 50);
      if (!meas_valid) begin
         n_chk++; n_fail++;
         $display("FAIL wait_valid: no meas_valid within %0d cycles", n);
      end
   endtask

   initial begin
      int n;
      bit seen;
      sys_rst = 1; mon_en = 0; chan_tgl = '0; inj = '0;
      per = '{5, 1, 0, 7};
      model_reset();
      repeat (3) step();
      chk("rst_meas_cnt", meas_cnt, 0);
      chk("rst_busy", busy, 0);
      #2 sys_rst = 0;
      repeat (20) step();
      chk("idle_busy", busy, 0);
      chk("idle_meas_valid", meas_valid, 0);

      // first report: settle window plus one run window
      mon_en = 1;
      wait_valid(n);
      chk("first_valid_latency", n, 2001);
      chk("ch0_cnt_p5", cnt_of(0), 200);
      chk("ch0_ok_p5", ch_ok[0], 1);
      chk("ch1_saturated", cnt_of(1), 255);
      chk("ch1_ok", ch_ok[1], 1);
      chk("ch2_cnt_const", cnt_of(2), 0);
      chk("ch2_dead", ch_dead[2], 1);
      chk("ch2_ok_const", ch_ok[2], 0);
      step();
      chk("valid_one_cycle", meas_valid, 0);

      // period 4 -> 250 edges, outside [190,210]
      per[0] = 4;
      wait_valid(n);
      chk("window_period_a", n, 999);
      wait_valid(n);
      chk("window_period_b", n, 1000);
      chk("ch0_cnt_p4", cnt_of(0), 250);
      chk("ch0_ok_p4", ch_ok[0], 0);

      // drop enable mid-window: no report, outputs hold
      repeat (500) step();
      mon_en = 0;
      step();
      chk("drop_busy", busy, 0);
      seen = 0;
      repeat (1200) begin
         step();
         if (meas_valid) seen = 1;
      end
      chk("drop_no_valid", seen, 0);
      chk("drop_hold_cnt", cnt_of(0), 250);
      mon_en = 1;
      wait_valid(n);
      chk("reenable_latency", n, 2001);

      // terminal-cycle edge on ch3, first-cycle edge of next window on ch2
      per = '{0, 0, 0, 0};
      wait_valid(n);
      repeat (996) step();
      inj = 4'b1000;
      step();
      inj = 4'b0100;
      step();
      wait_valid(n);
      chk("term_valid_pos", n, 2);
      chk("term_edge_closing", cnt_of(3), 1);
      chk("late_edge_excluded", cnt_of(2), 0);
      wait_valid(n);
      chk("next_window_ch3", cnt_of(3), 0);
      chk("next_window_ch2", cnt_of(2), 1);
      chk("next_window_dead2", ch_dead[2], 0);

      // asynchronous reset mid-run, between clock edges
      per = '{5, 1, 0, 7};
      repeat (300) step();
      #2 sys_rst = 1;
      chan_tgl = '0;
      model_reset();
      #1;
      chk("async_rst_cnt", meas_cnt, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_ok", ch_ok, 0);
      chk("async_rst_dead", ch_dead, 0);
      chk("async_rst_valid", meas_valid, 0);
      repeat (3) step();
      #2 sys_rst = 0;
      wait_valid(n);
      chk("post_rst_latency", n, 2001);
      chk("post_rst_ch0", cnt_of(0), 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
